// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiply/divide path.
// Contents:
//   MULDIV_* : operation codes driven by decode onto the unit's op port
//   md_state_e : multiply/divide sequencer states
//   muldiv_op_* helpers : classify an op code (valid / signed / divide)
package mips_pkg;

    localparam logic [2:0] MULDIV_NONE  = 3'd0;
    localparam logic [2:0] MULDIV_MULT  = 3'd1;
    localparam logic [2:0] MULDIV_MULTU = 3'd2;
    localparam logic [2:0] MULDIV_DIV   = 3'd3;
    localparam logic [2:0] MULDIV_DIVU  = 3'd4;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIX  = 2'd3
    } md_state_e;

    // True for the four op codes that start an operation.
    function automatic logic muldiv_op_valid(input logic [2:0] op);
        logic v;
        case (op)
            MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU: v = 1'b1;
            default:                                            v = 1'b0;
        endcase
        return v;
    endfunction

    // True for the two's-complement variants.
    function automatic logic muldiv_op_signed(input logic [2:0] op);
        return (op == MULDIV_MULT) || (op == MULDIV_DIV);
    endfunction

    // True for the divide variants.
    function automatic logic muldiv_op_is_div(input logic [2:0] op);
        return (op == MULDIV_DIV) || (op == MULDIV_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   is_div   : 1 = restoring divide step, 0 = shift-add multiply step
//   acc      : 2*WIDTH accumulator
//              multiply: {partial product, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   operand  : multiplicand (multiply) or divisor (divide), magnitudes only
//   acc_next : accumulator after this iteration
module muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] trial_s;

    // Compute both candidate steps and select by operation type.
    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set,
        // keep the carry, then shift the whole accumulator right.
        if (acc[0]) begin
            sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        end else begin
            sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
        // Divide: shift the next dividend bit into the remainder and try
        // subtracting. The extra bit is the borrow: set means "restore".
        rem_sh_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, operand};
        if (is_div) begin
            if (!trial_s[WIDTH]) begin
                acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start, op       : issue strobe and MULDIV_* op code from decode
//   in1, in2        : rs / rt operands, sampled only at the accept edge
//   hi_we, lo_we    : MTHI / MTLO write enables (honoured only when idle)
//   wdata           : MTHI / MTLO data
//   busy            : operation in flight (stall request)
//   done            : one-cycle pulse when HI/LO take a new result
//   hi, lo          : HI / LO registers
// Every operation takes WIDTH iteration cycles plus one sign-fix cycle.
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state_r;
    md_state_e          state_nx_s;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opd_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               div0_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               accept_s;
    logic               last_s;
    logic               op_mul_s;
    logic               op_signed_s;
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    assign accept_s    = (state_r == MD_IDLE) && start && muldiv_op_valid(op);
    assign last_s      = (cnt_r == CW'(WIDTH - 1));
    assign op_mul_s    = !muldiv_op_is_div(op);
    assign op_signed_s = muldiv_op_signed(op);

    // Operand magnitudes for signed ops; the signs are carried separately.
    always_comb begin
        if (op_signed_s && in1[WIDTH-1]) begin
            a_abs_s = -in1;
        end else begin
            a_abs_s = in1;
        end
        if (op_signed_s && in2[WIDTH-1]) begin
            b_abs_s = -in2;
        end else begin
            b_abs_s = in2;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_r),
        .acc      (acc_r),
        .operand  (opd_r),
        .acc_next (step_acc_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MD_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (accept_s) begin
                    if (op_mul_s) begin
                        state_nx_s = MD_MUL;
                    end else begin
                        state_nx_s = MD_DIV;
                    end
                end else begin
                    state_nx_s = MD_IDLE;
                end
            end
            MD_MUL, MD_DIV: begin
                if (last_s) begin
                    state_nx_s = MD_FIX;
                end else begin
                    state_nx_s = state_r;
                end
            end
            MD_FIX:  state_nx_s = MD_IDLE;
            default: state_nx_s = MD_IDLE;
        endcase
    end

    // Operand capture at accept, then one datapath iteration per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            opd_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (accept_s) begin
                        // Multiply iterates over the multiplier bits held in
                        // the low half; divide shifts the dividend out of it.
                        if (op_mul_s) begin
                            acc_r <= {{WIDTH{1'b0}}, b_abs_s};
                            opd_r <= a_abs_s;
                        end else begin
                            acc_r <= {{WIDTH{1'b0}}, a_abs_s};
                            opd_r <= b_abs_s;
                        end
                        cnt_r    <= {CW{1'b0}};
                        is_div_r <= !op_mul_s;
                        neg_q_r  <= op_signed_s && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                        neg_r_r  <= op_signed_s && in1[WIDTH-1];
                        div0_r   <= !op_mul_s && (in2 == {WIDTH{1'b0}});
                    end
                end
                MD_MUL, MD_DIV: begin
                    acc_r <= step_acc_s;
                    cnt_r <= cnt_r + CW'(1'b1);
                end
                default: begin
                end
            endcase
        end
    end

    // Sign correction of the magnitude result.
    always_comb begin
        prod_s   = acc_r;
        res_hi_s = acc_r[2*WIDTH-1:WIDTH];
        res_lo_s = acc_r[WIDTH-1:0];
        if (is_div_r) begin
            // Divide by zero: quotient forced to all ones. The remainder is
            // then |dividend|, so the sign fix below restores the raw dividend.
            if (div0_r) begin
                res_lo_s = {WIDTH{1'b1}};
            end else if (neg_q_r) begin
                res_lo_s = -acc_r[WIDTH-1:0];
            end else begin
                res_lo_s = acc_r[WIDTH-1:0];
            end
            if (neg_r_r) begin
                res_hi_s = -acc_r[2*WIDTH-1:WIDTH];
            end else begin
                res_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
        end else begin
            if (neg_q_r) begin
                prod_s = -acc_r;
            end else begin
                prod_s = acc_r;
            end
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // HI/LO registers: result writeback at FIX, MTHI/MTLO only when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            done_r <= 1'b0;
        end else if (state_r == MD_FIX) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            if (state_r == MD_IDLE) begin
                if (hi_we) begin
                    hi_r <= wdata;
                end
                if (lo_we) begin
                    lo_r <= wdata;
                end
            end
        end
    end

    assign busy = (state_r != MD_IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: the issuing side pushes the
// reference {HI,LO} and the expected completion cycle; a monitor pops and
// compares on every done pulse.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dropped = 0;
    int exp_dropped = 0;
    logic [63:0] sb_q[$];
    int          due_q[$];

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to time completions.
    always @(posedge clk) cyc <= cyc + 1;

    // A start presented while busy is silently dropped by the unit; count it.
    always @(posedge clk) begin
        if (!rst && start && busy && (op >= 3'd1) && (op <= 3'd4))
            dropped <= dropped + 1;
    end

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Reference: plain 64-bit arithmetic from the architectural definition.
    function automatic logic [63:0] model(input logic [2:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'h0;
        case (o)
            3'd1: res = 64'(sa * sb);
            3'd2: res = {32'h0, a} * {32'h0, b};
            3'd3: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'h0;
        endcase
        return res;
    endfunction

    // Monitor: compare every done pulse against the scoreboard head.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            sb_q.delete();
            due_q.delete();
        end else if (done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 at cycle %0d, expected no completion", cyc);
            end else begin
                logic [63:0] e;
                int d;
                e = sb_q.pop_front();
                d = due_q.pop_front();
                check("result_hi", {32'h0, hi}, {32'h0, e[63:32]});
                check("result_lo", {32'h0, lo}, {32'h0, e[31:0]});
                check("done_cycle", 64'(cyc), 64'(d));
            end
        end
    end

    // Issue one operation; optionally wait for completion and check busy length.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input bit wait_done);
        int n;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1;
        sb_q.push_back(model(o, a, b));
        due_q.push_back(cyc + 33);
        start = 1'b0;
        op    = 3'd0;
        in1   = $urandom;
        in2   = $urandom;
        if (wait_done) begin
            n = 0;
            while (busy && n < 40) begin
                n++;
                @(posedge clk);
                #1;
            end
            check("busy_cycles", 64'(n), 64'd33);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_within_bound", {63'h0, busy}, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        int sel;
        rst = 1'b1; start = 1'b0; op = 3'd0; in1 = 32'h0; in2 = 32'h0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_done", {63'h0, done}, 64'h0);
        check("reset_hi", {32'h0, hi}, 64'h0);
        check("reset_lo", {32'h0, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operations from the test plan.
        do_op(MULDIV_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
        check("mult_7_m3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op(MULDIV_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        check("mult_m1_m1", {hi, lo}, 64'h0000_0000_0000_0001);
        do_op(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(MULDIV_DIVU, 32'd100, 32'd7, 1'b1);
        check("divu_100_7", {hi, lo}, 64'h0000_0002_0000_000E);
        do_op(MULDIV_DIV, 32'h64, 32'h0, 1'b1);
        check("div_by_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        do_op(MULDIV_DIVU, 32'h8000_0001, 32'h0, 1'b1);
        check("divu_by_zero", {hi, lo}, 64'h8000_0001_FFFF_FFFF);
        do_op(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("div_minneg_m1", {hi, lo}, 64'h0000_0000_8000_0000);

        // Start and MTHI while busy are both ignored.
        do_op(MULDIV_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = MULDIV_MULT; in1 = 32'd3; in2 = 32'd3;
        hi_we = 1'b1; wdata = 32'hAA;
        exp_dropped++;
        @(negedge clk);
        start = 1'b0; op = 3'd0; hi_we = 1'b0;
        check("hi_held_while_busy", {32'h0, hi}, 64'h0000_0000_8000_0000 >> 32);
        wait_idle();
        @(negedge clk);
        check("busy_ignore_result", {hi, lo}, 64'h0000_0002_0000_000E);

        // MTHI / MTLO when idle.
        hi_we = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_idle", {hi, lo}, 64'h0000_00AA_0000_000E);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, 64'h1234_5678_1234_5678);
        lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo_idle", {hi, lo}, 64'h1234_5678_0BAD_F00D);

        // Reserved and NONE ops are ignored.
        start = 1'b1; op = 3'd5; in1 = 32'd9; in2 = 32'd9;
        @(negedge clk);
        check("op5_ignored", {63'h0, busy}, 64'h0);
        op = 3'd0;
        @(negedge clk);
        start = 1'b0;
        check("op0_ignored", {63'h0, busy}, 64'h0);

        // Write accepted in the same cycle as start commits, then is overwritten.
        start = 1'b1; op = MULDIV_MULTU; in1 = 32'd5; in2 = 32'd6;
        hi_we = 1'b1; wdata = 32'h55;
        @(posedge clk);
        #1;
        sb_q.push_back(model(MULDIV_MULTU, 32'd5, 32'd6));
        due_q.push_back(cyc + 33);
        start = 1'b0; op = 3'd0; hi_we = 1'b0;
        check("write_at_accept", {32'h0, hi}, 64'h55);
        wait_idle();
        @(negedge clk);
        check("result_after_write", {hi, lo}, 64'h0000_0000_0000_001E);

        // Reset in the middle of a MULT aborts it with no completion.
        do_op(MULDIV_MULT, 32'h0001_2345, 32'h0000_0777, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", {63'h0, busy}, 64'h0);
        check("midrst_done", {63'h0, done}, 64'h0);
        check("midrst_hilo", {hi, lo}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        do_op(MULDIV_MULTU, 32'd3, 32'd5, 1'b1);
        check("after_rst_result", {hi, lo}, 64'h0000_0000_0000_000F);

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            o   = 3'($urandom_range(1, 4));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin
                a = $urandom_range(0, 255);
                b = $urandom_range(1, 15);
            end
            if (sel == 2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            do_op(o, a, b, 1'b1);
        end

        repeat (40) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        check("dropped_starts", 64'(dropped), 64'(exp_dropped));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
